// File: rtl/seq_checker_if.sv
// Bundle of the serial-checker signals shared by the stream source and the
// checker. The source drives data, qualifier and the counter clear. The
// checker returns lock, match and error status.
interface seq_checker_if #(
    parameter int CNT_W = 8
) ();
    logic             din;
    logic             din_vld;
    logic             err_clr;
    logic             locked;
    logic             match;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    // Stream source / status consumer side
    modport master (
        output din, din_vld, err_clr,
        input  locked, match, err, err_cnt
    );

    // Checker side
    modport slave (
        input  din, din_vld, err_clr,
        output locked, match, err, err_cnt
    );
endinterface

// File: rtl/seq_checker.sv
// seq_checker: hunts for a cyclic PATTERN in a qualified serial stream.
// It locks after LOCK_CNT clean periods, checks every bit while locked, and
// drops lock after UNLOCK_CNT consecutive bad periods.
// PATTERN[LEN-1] is the first bit of a period in time.
// Optional macro SEQ_CHK_ERRCNT_EN builds the saturating error counter.
// Without the macro, err_cnt is tied to zero and err_clr is ignored.
module seq_checker #(
    parameter int             LEN        = 6,
    parameter logic [LEN-1:0] PATTERN    = 6'b001011,
    parameter int             LOCK_CNT   = 2,
    parameter int             UNLOCK_CNT = 2,
    parameter int             CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_checker_if.slave  bus
);
    localparam int PH_W   = $clog2(LEN);
    localparam int FILL_W = $clog2(LEN + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(LEN - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_DROP  = BAD_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic               bad_cur_q, bad_cur_d;   // current LOCK period already has an error
    logic               locked_q, locked_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic               exp_bit;
    logic               mis;

    // The bit that the current phase should carry.
    assign exp_bit = PATTERN[LAST_PH - phase_q];
    assign mis     = (bus.din != exp_bit);

    // Next-state and pulse decode. This logic acts only on qualified bits.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        phase_d   = phase_q;
        good_d    = good_q;
        bad_d     = bad_q;
        bad_cur_d = bad_cur_q;
        match_d   = 1'b0;
        err_d     = 1'b0;

        if (bus.din_vld) begin
            sr_d   = {sr_q[LEN-2:0], bus.din};
            fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

            unique case (state_q)
                HUNT: begin
                    if ((fill_d == FILL_FULL) && (sr_d == PATTERN)) begin
                        match_d   = 1'b1;
                        phase_d   = '0;
                        good_d    = GOOD_W'(1);
                        bad_d     = '0;
                        bad_cur_d = 1'b0;
                        state_d   = (LOCK_CNT == 1) ? LOCK : VERIFY;
                    end
                end

                VERIFY: begin
                    if (mis) begin
                        // Keep the shift register so that hunting resumes on the next bit.
                        state_d = HUNT;
                        good_d  = '0;
                        phase_d = '0;
                    end else if (phase_q == LAST_PH) begin
                        phase_d = '0;
                        match_d = 1'b1;
                        good_d  = good_q + GOOD_W'(1);
                        if ((good_q + GOOD_W'(1)) == GOOD_LOCK) begin
                            state_d   = LOCK;
                            bad_cur_d = 1'b0;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                LOCK: begin
                    err_d = mis;
                    if (phase_q == LAST_PH) begin
                        phase_d   = '0;
                        bad_cur_d = 1'b0;
                        if (bad_cur_q || mis) begin
                            if ((bad_q + BAD_W'(1)) == BAD_DROP) begin
                                state_d = HUNT;
                                good_d  = '0;
                                bad_d   = '0;
                            end else begin
                                bad_d = bad_q + BAD_W'(1);
                            end
                        end else begin
                            bad_d   = '0;
                            match_d = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        if (mis) begin
                            bad_cur_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCK);
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            fill_q    <= '0;
            phase_q   <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            bad_cur_q <= 1'b0;
            locked_q  <= 1'b0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            phase_q   <= phase_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            bad_cur_q <= bad_cur_d;
            locked_q  <= locked_d;
            match_q   <= match_d;
            err_q     <= err_d;
        end
    end

    assign bus.locked = locked_q;
    assign bus.match  = match_q;
    assign bus.err    = err_q;

`ifdef SEQ_CHK_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] err_cnt_q;

    // Saturating error count. The count updates on the same edge as err.
    // A clear that coincides with an error leaves the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            err_cnt_q <= CNT_W'(err_d);
        end else if (err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.err_cnt    = {CNT_W{1'b0}};
`endif

endmodule
